data_mem_pipe: RTL and testbench
================================

DATA_MEM_PIPE -- requirements
Module: data_mem_pipe

Interface
REQ-001 The block SHALL have parameter DEPTH_WORDS, default 3072, giving the number of 32-bit words.
REQ-002 The block SHALL have parameter LAT, default 2, legal range 1..8, giving the number of cycles from request accept to response.
REQ-003 The block SHALL have parameter IDX_W, default $clog2(DEPTH_WORDS), giving the word-index width.
REQ-004 Port clk SHALL be an input, 1 bit wide, and be the single clock; all state changes on its rising edge.
REQ-005 Port reset SHALL be an input, 1 bit wide, and be the asynchronous, active-low reset.
REQ-006 Port req_valid SHALL be an input, 1 bit wide: a request is present.
REQ-007 Port req_ready SHALL be an output, 1 bit wide: the block can accept a request.
REQ-008 Port req_we SHALL be an input, 1 bit wide: 1 = store, 0 = load.
REQ-009 Port req_op SHALL be an input, 3 bits wide, with encoding 000 word, 001 byte signed, 010 byte unsigned, 011 half signed, 100 half unsigned, 101-111 illegal.
REQ-010 Port req_addr SHALL be an input, 32 bits wide: the byte address.
REQ-011 Port req_wdata SHALL be an input, 32 bits wide: store data, right-aligned.
REQ-012 Port req_pc SHALL be an input, 32 bits wide: the issuing instruction PC, used for trace only.
REQ-013 Port resp_valid SHALL be an output, 1 bit wide, and be a one-cycle pulse for a completed request.
REQ-014 Port resp_rdata SHALL be an output, 32 bits wide, carrying the extended load data.
REQ-015 Port resp_exc SHALL be an output, 1 bit wide: the request faulted.
REQ-016 Port busy SHALL be an output, 1 bit wide: the block is clearing memory or has a request in flight.

Function
REQ-017 The FSM SHALL have four states: CLEAR, IDLE, WAIT, RESP.
REQ-018 In CLEAR, the block SHALL write zero to one word per cycle, with index 0..DEPTH_WORDS-1, then go to IDLE.
REQ-019 req_ready SHALL be 1 only in IDLE; a request is accepted when req_valid and req_ready are both 1.
REQ-020 On accept, the block SHALL register all request fields; IDLE goes to WAIT if LAT>1, else to RESP.
REQ-021 WAIT SHALL count LAT-1 cycles, then go to RESP; RESP lasts one cycle, asserts resp_valid and returns to IDLE, so the response comes LAT cycles after accept.
REQ-022 Word index SHALL be addr[IDX_W+1:2]; a request faults if addr[31:2] >= DEPTH_WORDS.
REQ-023 A request SHALL also fault if half with addr[0]=1, word with addr[1:0]!=0, or op 101-111.
REQ-024 On a fault, the block SHALL set resp_exc=1 and resp_rdata=0, and memory is unchanged.
REQ-025 A load SHALL select the byte at lane addr[1:0] or the half at lane addr[1], then sign-extend for ops 001/011 or zero-extend for 010/100.
REQ-026 A store SHALL write only the addressed lanes (byte: 1 lane, half: 2 lanes, word: 4 lanes) and leave other bytes intact; ops 010/100 store as byte/half.
REQ-027 A store SHALL commit on the RESP cycle edge; during RESP, resp_rdata SHALL be 0.
REQ-028 A load in RESP SHALL return memory contents including any store committed at an earlier RESP edge (no stale data).
REQ-029 busy SHALL be 1 in CLEAR, WAIT and RESP, and 0 in IDLE.

Reset
REQ-030 reset low SHALL immediately force state CLEAR, clear index 0, and set req_ready=0, resp_valid=0, resp_exc=0, resp_rdata=0 and busy=1.
REQ-031 reset asserted mid-request SHALL abort the request: no store commits and no resp_valid is produced.
REQ-032 The memory array SHALL not be reset directly; zeroing SHALL occur only via CLEAR after reset deasserts.

Configuration
REQ-033 With macro DM_TRACE_EN defined, each committed store SHALL print "<time>@<pc>: *<addr> <= <merged word>" in hex, with the word-aligned address.
REQ-034 Without DM_TRACE_EN, the block SHALL contain no display statements and its behaviour SHALL be otherwise identical.

Structure
REQ-035 A shared package SHALL hold the req_op encodings, the FSM state enum, and the lane-select/extend function.
REQ-036 A sub-module dm_lane_merge SHALL be used: a combinational byte-enable merge and load extend, shared with future cache blocks.

Verification
REQ-037 Release reset -> busy=1 for exactly DEPTH_WORDS cycles, then req_ready=1; any load then returns 0x00000000.
REQ-038 SW 0x8badf00d @0x10, then LB @0x13 / LBU @0x13 / LH @0x12 / LHU @0x10 -> responses 0xffffff8b, 0x0000008b, 0xffff8bad, 0x0000f00d.
REQ-039 SB 0x12 @0x11 over word 0x8badf00d -> LW @0x10 returns 0x8bad120d.
REQ-040 LW @0x2 and SH @0x5 -> resp_exc=1, rdata 0, memory unchanged; a byte load at address 4*DEPTH_WORDS -> resp_exc=1.
REQ-041 LAT=1 and LAT=4 builds -> resp_valid exactly 1 and 4 cycles after accept; req_ready=0 between accept and response.
REQ-042 reset pulsed during WAIT of a SW -> no resp_valid and no write; memory reads 0 after the CLEAR completes.

Source files
------------

// File: rtl/data_mem_pipe_pkg.sv
// rtl/data_mem_pipe_pkg.sv - shared op encodings, FSM states and load lane-select/extend helper
package data_mem_pipe_pkg;

    localparam logic [2:0] OP_W  = 3'b000;
    localparam logic [2:0] OP_B  = 3'b001;
    localparam logic [2:0] OP_BU = 3'b010;
    localparam logic [2:0] OP_H  = 3'b011;
    localparam logic [2:0] OP_HU = 3'b100;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_IDLE  = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } dm_state_e;

    function automatic logic op_is_byte(input logic [2:0] op);
        return (op == OP_B) || (op == OP_BU);
    endfunction

    function automatic logic op_is_half(input logic [2:0] op);
        return (op == OP_H) || (op == OP_HU);
    endfunction

    function automatic logic [31:0] ld_extend(input logic [31:0] word,
                                              input logic [2:0]  op,
                                              input logic [1:0]  lane);
        logic [31:0] sh;
        logic [7:0]  b;
        logic [15:0] h;
        sh = word >> {lane, 3'b000};
        b  = sh[7:0];
        h  = lane[1] ? word[31:16] : word[15:0];
        case (op)
            OP_W:    return word;
            OP_B:    return {{24{b[7]}}, b};
            OP_BU:   return {24'h0, b};
            OP_H:    return {{16{h[15]}}, h};
            OP_HU:   return {16'h0, h};
            default: return 32'h0;
        endcase
    endfunction

endpackage

// File: rtl/dm_lane_merge.sv
// rtl/dm_lane_merge.sv - combinational byte-enable store merge and load extend
module dm_lane_merge
    import data_mem_pipe_pkg::*;
(
    input  logic [31:0] i_old_word,
    input  logic [31:0] i_wdata,
    input  logic [2:0]  i_op,
    input  logic [1:0]  i_lane,
    output logic [31:0] o_merged,
    output logic [31:0] o_load
);

    logic [3:0]  w_be;
    logic [31:0] w_rep;

    always_comb begin
        w_be  = 4'hf;
        w_rep = i_wdata;
        if (op_is_byte(i_op)) begin
            w_be  = 4'b0001 << i_lane;
            w_rep = {4{i_wdata[7:0]}};
        end else if (op_is_half(i_op)) begin
            w_be  = i_lane[1] ? 4'b1100 : 4'b0011;
            w_rep = {2{i_wdata[15:0]}};
        end
        o_merged = i_old_word;
        for (int i = 0; i < 4; i++) begin
            if (w_be[i]) o_merged[i*8 +: 8] = w_rep[i*8 +: 8];
        end
    end

    assign o_load = ld_extend(i_old_word, i_op, i_lane);

endmodule

// File: rtl/data_mem_pipe.sv
// rtl/data_mem_pipe.sv - fixed-latency data memory with clear-on-reset; store trace under DM_TRACE_EN
module data_mem_pipe
    import data_mem_pipe_pkg::*;
#(
    parameter int DEPTH_WORDS = 3072,
    parameter int LAT         = 2,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [31:0] req_pc,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_exc,
    output logic        busy
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH_WORDS - 1);
    localparam logic [2:0]       CNT_LAST = 3'(LAT - 2);

    dm_state_e        r_state;
    logic [IDX_W-1:0] r_idx;
    logic [2:0]       r_cnt;
    logic             r_we;
    logic [2:0]       r_op;
    logic [31:0]      r_addr;
    logic [31:0]      r_wdata;
    logic [31:0]      r_pc;
    logic             r_exc;
    logic [31:0]      r_mem [DEPTH_WORDS];

    logic             w_req_fault;
    logic [IDX_W-1:0] w_idx;
    logic [31:0]      w_old;
    logic [31:0]      w_merged;
    logic [31:0]      w_load;
    logic             w_mem_we;
    logic [IDX_W-1:0] w_mem_idx;
    logic [31:0]      w_mem_wdata;

    always_comb begin
        w_req_fault = ({2'b00, req_addr[31:2]} >= 32'(DEPTH_WORDS));
        case (req_op)
            OP_W:        if (req_addr[1:0] != 2'b00) w_req_fault = 1'b1;
            OP_H, OP_HU: if (req_addr[0]) w_req_fault = 1'b1;
            OP_B, OP_BU: ;
            default:     w_req_fault = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_CLEAR;
            r_idx   <= '0;
            r_cnt   <= '0;
            r_we    <= 1'b0;
            r_op    <= OP_W;
            r_addr  <= '0;
            r_wdata <= '0;
            r_pc    <= '0;
            r_exc   <= 1'b0;
        end else begin
            case (r_state)
                ST_CLEAR: begin
                    if (r_idx == LAST_IDX) r_state <= ST_IDLE;
                    else                   r_idx   <= r_idx + 1'b1;
                end
                ST_IDLE: begin
                    if (req_valid) begin
                        r_we    <= req_we;
                        r_op    <= req_op;
                        r_addr  <= req_addr;
                        r_wdata <= req_wdata;
                        r_pc    <= req_pc;
                        r_exc   <= w_req_fault;
                        r_cnt   <= '0;
                        r_state <= (LAT > 1) ? ST_WAIT : ST_RESP;
                    end
                end
                ST_WAIT: begin
                    if (r_cnt == CNT_LAST) r_state <= ST_RESP;
                    else                   r_cnt   <= r_cnt + 1'b1;
                end
                ST_RESP:  r_state <= ST_IDLE;
                default:  r_state <= ST_CLEAR;
            endcase
        end
    end

    assign w_idx = r_addr[IDX_W+1:2];
    assign w_old = r_mem[w_idx];

    dm_lane_merge u_lane_merge (
        .i_old_word (w_old),
        .i_wdata    (r_wdata),
        .i_op       (r_op),
        .i_lane     (r_addr[1:0]),
        .o_merged   (w_merged),
        .o_load     (w_load)
    );

    // Gated by reset so a held reset never touches the array; the store lands on the edge leaving RESP.
    assign w_mem_we    = reset && ((r_state == ST_CLEAR) ||
                                   (r_state == ST_RESP && r_we && !r_exc));
    assign w_mem_idx   = (r_state == ST_CLEAR) ? r_idx : w_idx;
    assign w_mem_wdata = (r_state == ST_CLEAR) ? 32'h0 : w_merged;

    always_ff @(posedge clk) begin
        if (w_mem_we) r_mem[w_mem_idx] <= w_mem_wdata;
    end

    assign req_ready  = (r_state == ST_IDLE);
    assign busy       = (r_state != ST_IDLE);
    assign resp_valid = (r_state == ST_RESP);
    assign resp_exc   = (r_state == ST_RESP) && r_exc;
    assign resp_rdata = (r_state == ST_RESP && !r_we && !r_exc) ? w_load : 32'h0;

`ifdef DM_TRACE_EN
    always_ff @(posedge clk) begin
        if (reset && r_state == ST_RESP && r_we && !r_exc)
            $display("%0t@%h: *%h <= %h", $time, r_pc, {r_addr[31:2], 2'b00}, w_merged);
    end
`else
    logic w_unused_pc;
    assign w_unused_pc = ^r_pc;
`endif

endmodule

// File: tb/tb_data_mem_pipe.sv
// tb/tb_data_mem_pipe.sv - directed self-checking bench for data_mem_pipe
module tb_data_mem_pipe;
    import data_mem_pipe_pkg::*;

    localparam int DEPTH = 3072;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_op = 3'b000;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [31:0] req_pc = 32'h0000_1000;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_exc;
    logic        busy;

    logic        s_valid [2];
    logic        s_ready [2];
    logic        s_resp_valid [2];
    logic [31:0] s_rdata [2];
    logic        s_exc [2];
    logic        s_busy [2];

    int n_cmp = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    data_mem_pipe #(.DEPTH_WORDS(DEPTH), .LAT(2)) u_dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_pc(req_pc), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_exc(resp_exc), .busy(busy)
    );

    for (genvar g = 0; g < 2; g++) begin : g_lat
        data_mem_pipe #(.DEPTH_WORDS(16), .LAT(g == 0 ? 1 : 4)) u_dut (
            .clk(clk), .reset(reset), .req_valid(s_valid[g]), .req_ready(s_ready[g]),
            .req_we(req_we), .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
            .req_pc(req_pc), .resp_valid(s_resp_valid[g]), .resp_rdata(s_rdata[g]),
            .resp_exc(s_exc[g]), .busy(s_busy[g])
        );
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic do_req(input string tag, input logic we, input logic [2:0] op,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_rdata, input logic exp_exc);
        int t;
        t = 0;
        while (!req_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        req_we = we; req_op = op; req_addr = addr; req_wdata = wdata;
        req_pc = req_pc + 32'd4;
        req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        t = 0;
        while (!resp_valid && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (!resp_valid) begin
            chk({tag, "_timeout"}, 32'd0, 32'd1);
        end else begin
            chk({tag, "_rdata"}, resp_rdata, exp_rdata);
            chk({tag, "_exc"}, {31'd0, resp_exc}, {31'd0, exp_exc});
        end
        @(negedge clk);
    endtask

    task automatic lat_test(input int k, input int exp_lat);
        int t;
        int got;
        logic rdy_seen;
        t = 0;
        while (!s_ready[k] && t < 100) begin
            @(negedge clk);
            t++;
        end
        req_we = 1'b0; req_op = OP_W; req_addr = 32'h4; req_wdata = '0;
        s_valid[k] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        s_valid[k] = 1'b0;
        got = 0;
        rdy_seen = 1'b0;
        for (int n = 1; n <= 12 && got == 0; n++) begin
            if (n > 1) @(negedge clk);
            if (s_resp_valid[k]) got = n;
            else if (s_ready[k]) rdy_seen = 1'b1;
        end
        chk($sformatf("lat%0d_cycles", exp_lat), got, exp_lat);
        chk($sformatf("lat%0d_ready_low", exp_lat), {31'd0, rdy_seen}, 32'd0);
        @(negedge clk);
        chk($sformatf("lat%0d_pulse", exp_lat), {31'd0, s_resp_valid[k]}, 32'd0);
    endtask

    task automatic wait_clear(input string tag, input int exp_cycles);
        int cnt;
        int pulses;
        cnt = busy ? 1 : 0;
        pulses = 0;
        for (int t = 0; t < 5000; t++) begin
            @(negedge clk);
            if (resp_valid) pulses++;
            if (!busy) break;
            cnt++;
        end
        chk({tag, "_busy_cycles"}, cnt, exp_cycles);
        chk({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
        chk({tag, "_no_resp"}, pulses, 0);
    endtask

    initial begin
        s_valid[0] = 1'b0;
        s_valid[1] = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_ready", {31'd0, req_ready}, 32'd0);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_exc", {31'd0, resp_exc}, 32'd0);
        chk("rst_rdata", resp_rdata, 32'h0);
        chk("rst_busy", {31'd0, busy}, 32'd1);

        reset = 1'b1;
        #1;
        wait_clear("init", DEPTH);

        do_req("lw_clear", 1'b0, OP_W, 32'h40, 32'h0, 32'h0, 1'b0);
        do_req("sw", 1'b1, OP_W, 32'h10, 32'h8badf00d, 32'h0, 1'b0);
        do_req("lb", 1'b0, OP_B, 32'h13, 32'h0, 32'hffffff8b, 1'b0);
        do_req("lbu", 1'b0, OP_BU, 32'h13, 32'h0, 32'h0000008b, 1'b0);
        do_req("lh", 1'b0, OP_H, 32'h12, 32'h0, 32'hffff8bad, 1'b0);
        do_req("lhu", 1'b0, OP_HU, 32'h10, 32'h0, 32'h0000f00d, 1'b0);
        do_req("sb", 1'b1, OP_B, 32'h11, 32'h00000012, 32'h0, 1'b0);
        do_req("lw_sb", 1'b0, OP_W, 32'h10, 32'h0, 32'h8bad120d, 1'b0);
        do_req("sh", 1'b1, OP_HU, 32'h12, 32'h1234beef, 32'h0, 1'b0);
        do_req("lw_sh", 1'b0, OP_W, 32'h10, 32'h0, 32'hbeef120d, 1'b0);
        do_req("lbu_lane0", 1'b0, OP_BU, 32'h10, 32'h0, 32'h0000000d, 1'b0);

        do_req("lw_misal", 1'b0, OP_W, 32'h2, 32'h0, 32'h0, 1'b1);
        do_req("sh_misal", 1'b1, OP_H, 32'h5, 32'h0000ffff, 32'h0, 1'b1);
        do_req("lw_after_sh", 1'b0, OP_W, 32'h4, 32'h0, 32'h0, 1'b0);
        do_req("lb_oob", 1'b0, OP_B, 32'h3000, 32'h0, 32'h0, 1'b1);
        do_req("op_illegal", 1'b0, 3'b101, 32'h10, 32'h0, 32'h0, 1'b1);
        do_req("sw_oob", 1'b1, OP_W, 32'h3000, 32'h11111111, 32'h0, 1'b1);
        do_req("lw_keep", 1'b0, OP_W, 32'h10, 32'h0, 32'hbeef120d, 1'b0);

        lat_test(0, 1);
        lat_test(1, 4);

        do_req("sw_pre", 1'b1, OP_W, 32'h20, 32'hdeadbeef, 32'h0, 1'b0);
        do_req("lw_pre", 1'b0, OP_W, 32'h20, 32'h0, 32'hdeadbeef, 1'b0);
        req_we = 1'b1; req_op = OP_W; req_addr = 32'h24; req_wdata = 32'hcafef00d;
        req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        chk("abort_in_wait", {31'd0, busy && !resp_valid}, 32'd1);
        reset = 1'b0;
        #1;
        chk("abort_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd1);
        chk("abort_ready", {31'd0, req_ready}, 32'd0);
        repeat (2) @(negedge clk);
        chk("abort_hold_resp", {31'd0, resp_valid}, 32'd0);
        reset = 1'b1;
        #1;
        wait_clear("reclear", DEPTH);
        do_req("lw_abort", 1'b0, OP_W, 32'h24, 32'h0, 32'h0, 1'b0);
        do_req("lw_cleared", 1'b0, OP_W, 32'h20, 32'h0, 32'h0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
